// File: rtl/clock_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_monitor
// Purpose  : Samples a slow clock that is asynchronous to iCLK and
//            synchronizes it. Emits one-cycle rise/fall strobes in the iCLK
//            domain, measures the high and low times in iCLK cycles, and
//            flags loss of toggling.
// Ports    : iCLK        - system clock, rising edge
//            RSTn        - synchronous active-low reset
//            clk_in      - monitored slow clock (asynchronous)
//            rise_stb    - one-cycle pulse per accepted rising edge
//            fall_stb    - one-cycle pulse per accepted falling edge
//            high_cycles - last measured high time
//            low_cycles  - last measured low time
//            meas_valid  - both measurements current since last lock/loss
//            lost        - no accepted edge for TIMEOUT cycles
// Options  : CLOCK_MONITOR_GLITCH_FILTER_EN - adds a third sync stage and
//            rejects one-cycle pulses. This adds one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module clock_monitor #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             iCLK,
    input  logic             RSTn,
    input  logic             clk_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] low_cycles,
    output logic             meas_valid,
    output logic             lost
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        MEAS1  = 3'd2,
        LOCKED = 3'd3,
        LOST   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_n;
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    logic             acc;          // an edge is accepted at the next clock edge
    logic             timeout_now;  // counter saturated with no edge pending
    logic             meas_ok;      // a reference edge exists to measure from

`ifdef CLOCK_MONITOR_GLITCH_FILTER_EN
    logic s3;

    // Accept a new level only once it has been stable for two samples.
    assign acc = (s2 == s3) && (s2 != lvl);

    always_ff @(posedge iCLK) begin
        if (!RSTn) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end
`else
    assign acc = (s2 != lvl);
`endif

    assign timeout_now = (cnt == TIMEOUT_CNT) && !acc;
    assign meas_ok     = (state == ARMED) || (state == MEAS1) || (state == LOCKED);

    // Synchronizer, accepted level, strobes, counter and measurements
    always_ff @(posedge iCLK) begin
        if (!RSTn) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            lvl         <= 1'b0;
            rise_stb    <= 1'b0;
            fall_stb    <= 1'b0;
            cnt         <= '0;
            high_cycles <= '0;
            low_cycles  <= '0;
        end else begin
            s1       <= clk_in;
            s2       <= s1;
            rise_stb <= acc && s2;
            fall_stb <= acc && !s2;
            if (acc) begin
                lvl <= s2;
            end
            // cnt is the number of cycles since the last strobe, counting
            // the strobe cycle itself as 1. It saturates at TIMEOUT.
            if (acc) begin
                cnt <= CNT_ONE;
            end else if (cnt != TIMEOUT_CNT) begin
                cnt <= cnt + CNT_ONE;
            end
            if (acc && meas_ok) begin
                if (s2) begin
                    low_cycles <= cnt;
                end else begin
                    high_cycles <= cnt;
                end
            end
        end
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and outputs. A pending edge takes priority over a timeout.
    always_comb begin
        state_n    = state;
        meas_valid = 1'b0;
        lost       = 1'b0;
        if (acc) begin
            case (state)
                IDLE:    state_n = ARMED;
                LOST:    state_n = ARMED;
                ARMED:   state_n = MEAS1;
                MEAS1:   state_n = LOCKED;
                LOCKED:  state_n = LOCKED;
                default: state_n = IDLE;
            endcase
        end else if (cnt == TIMEOUT_CNT) begin
            state_n = LOST;
        end
        meas_valid = (state == LOCKED) && !timeout_now;
        lost       = (state == LOST) || timeout_now;
    end

endmodule
`default_nettype wire
